mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle MIPS core; next generation of the single-cycle processor top.
- One shared instruction/data memory port with a ready handshake, so wait-state memory is supported.
- Each instruction runs as a sequence of FSM states instead of completing in one cycle.
- Instantiated by the system top next to an external unified memory.

Parameters:
DATA_W, 32, datapath and register width (>=16; immediates sign-extended from 16 bits)
ADDR_W, 8, word-address width of PC and memory port
ALLOW_ILLEGAL_HALT, 1, 1: an undefined opcode/funct halts with illegal=1; 0: it executes as a NOP

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
mem_req  out  1  memory access request
mem_we  out  1  1=write, 0=read; valid while mem_req=1
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  read data, valid when mem_ready=1
mem_ready  in  1  access completes at this edge when mem_req=1
pc_out  out  ADDR_W  current PC (debug)
halted  out  1  core stopped
illegal  out  1  stop caused by an undefined instruction

Behaviour:
- Reset (rst_n=0 at clk edge, from any state including mid-stall):
  - PC=0; state=FETCH; all 32 registers=0.
  - mem_req=0, mem_we=0, halted=0, illegal=0.
  - mem_addr and mem_wdata=0.
  - A pending memory access is abandoned.
- ISA and encoding:
  - Standard MIPS fields. Supported: R-type add/sub/and/or/slt (op 0x00, funct 0x20/0x22/0x24/0x25/0x2A), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02, halt 0x3F.
  - Word addressing throughout.
  - Arithmetic wraps modulo 2^DATA_W; there are no overflow traps.
  - slt is a signed compare.
- Register file: $0 reads as 0; writes to $0 are discarded.
- State machine:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC; hold until mem_ready=1. On that edge: IR<=mem_rdata, PC<=PC+1 (wraps mod 2^ADDR_W).
  - DECODE: A<=R[rs], B<=R[rt]; ALUOut<=PC+signext(imm). Next state by opcode:
    - R-type -> EXEC_R
    - lw/sw -> MEM_ADDR
    - addi -> EXEC_I
    - beq -> BRANCH
    - j -> JUMP
    - halt -> HALT
    - undefined -> HALT with illegal=1 (ALLOW_ILLEGAL_HALT=1), else FETCH
  - EXEC_R: ALUOut<=A op B -> WB_R.
  - WB_R: R[rd]<=ALUOut -> FETCH.
  - EXEC_I: ALUOut<=A+signext(imm) -> WB_I.
  - WB_I: R[rt]<=ALUOut -> FETCH.
  - MEM_ADDR: ALUOut<=A+signext(imm) -> MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: mem_req=1, mem_we=0, mem_addr=ALUOut[ADDR_W-1:0]; on mem_ready: MDR<=mem_rdata -> MEM_WB.
  - MEM_WB: R[rt]<=MDR -> FETCH.
  - MEM_WR: mem_req=1, mem_we=1, mem_addr=ALUOut[ADDR_W-1:0], mem_wdata=B; on mem_ready -> FETCH.
  - BRANCH: if A==B then PC<=ALUOut[ADDR_W-1:0] (i.e. PC+1+imm); -> FETCH.
  - JUMP: PC<=IR[ADDR_W-1:0] -> FETCH.
  - HALT: halted=1; no memory requests; state held until reset.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered.
  - They stay stable for the whole request until the completing edge.
  - mem_req deasserts in the cycle after completion.
  - mem_ready while mem_req=0 is ignored.
- Cycle counts with zero-wait memory (mem_ready=1 on the first request cycle):
  - beq, j: 3
  - add/sub/and/or/slt, addi, sw: 4
  - lw: 5
  - Each wait cycle adds 1.
- Boundaries:
  - Branch/jump/lw/sw addresses are truncated to ADDR_W bits.
  - PC increments past 2^ADDR_W-1 wrap to 0.
  - A halt fetched at any PC sets halted the cycle after DECODE.

Test Plan:
- Reset and zero-wait add:
  - Memory at 0: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; halt.
  - Required: $3=2; halted=1 at cycle 15 after reset release; illegal=0.
- lw/sw with wait states:
  - mem_ready delayed 2 cycles on every access.
  - sw $1,4($0); lw $4,4($0) with $1=0xDEADBEEF.
  - Required: mem word 4 = 0xDEADBEEF; $4=0xDEADBEEF; lw takes 9 cycles.
  - Addr/data/we stay stable throughout each stall.
- beq taken and not-taken:
  - $1=$2=7, beq $1,$2,+2 at PC=3 -> next fetch addr 6.
  - With $2=8 -> next fetch addr 4.
  - Both take 3 cycles.
- $0 protection and slt sign:
  - addi $0,$0,9 -> $0 reads 0.
  - slt $5,$6,$7 with $6=-1, $7=1 -> $5=1.
- Illegal opcode:
  - Opcode 0x3E with ALLOW_ILLEGAL_HALT=1 -> halted=1, illegal=1, mem_req stays 0 after.
  - With ALLOW_ILLEGAL_HALT=0 -> fetch continues at PC+1.
- Reset mid-stall:
  - Assert rst_n=0 during a MEM_RD stall with mem_ready held 0.
  - Required: next cycle mem_req=0, pc_out=0, state FETCH; the first request after release targets address 0.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
// Multi-cycle MIPS core (add/sub/and/or/slt, lw, sw, beq, addi, j, halt)
// sharing one word-addressed instruction/data memory port with a ready
// handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   mem_req    memory access request (registered)
//   mem_we     1=write, 0=read, valid while mem_req=1
//   mem_addr   word address
//   mem_wdata  store data
//   mem_rdata  read data, valid when mem_ready=1
//   mem_ready  access completes at this edge when mem_req=1
//   pc_out     current PC (debug)
//   halted     core stopped
//   illegal    stop caused by an undefined instruction
//
// state    | meaning
// ---------+-----------------------------------------------------
// FETCH    | request IR at PC, wait for ready, PC+1
// DECODE   | read rs/rt into A/B, ALUOut = PC+imm, dispatch on opcode
// EXEC_R   | ALUOut = A op B
// WB_R     | R[rd] = ALUOut
// EXEC_I   | ALUOut = A + imm
// WB_I     | R[rt] = ALUOut
// MEM_ADDR | ALUOut = A + imm, launch load or store
// MEM_RD   | load in flight, MDR = rdata on ready
// MEM_WB   | R[rt] = MDR
// MEM_WR   | store in flight
// BRANCH   | PC = ALUOut when A == B
// JUMP     | PC = IR[ADDR_W-1:0]
// HALT     | stopped until reset
module mips_multicycle_core #(
    parameter int DATA_W             = 32,
    parameter int ADDR_W             = 8,
    parameter int ALLOW_ILLEGAL_HALT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
        MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [31:0]         ir;
    logic [DATA_W-1:0]   a, b, alu_out, mdr;
    logic [DATA_W-1:0]   regs [32];

    logic [5:0]          op, funct;
    logic [4:0]          rs, rt, rd;
    logic [DATA_W-1:0]   imm_ext, eff_addr, alu_r;
    logic                funct_ok, op_ok;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_ext  = DATA_W'($signed(ir[15:0]));
    assign eff_addr = a + imm_ext;
    assign pc_out   = pc;

    always_comb begin
        alu_r    = '0;
        funct_ok = 1'b1;
        case (funct)
            6'h20:   alu_r = a + b;
            6'h22:   alu_r = a - b;
            6'h24:   alu_r = a & b;
            6'h25:   alu_r = a | b;
            6'h2A:   alu_r = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_R:                                   op_ok = funct_ok;
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW,
            OP_HALT:                                op_ok = 1'b1;
            default:                                op_ok = 1'b0;
        endcase
    end

    // Every path back to FETCH launches the next instruction request on the
    // same edge, so a fetch starts without an idle cycle. Only the FETCH
    // entered from reset sees mem_req=0 and issues the request itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ready) begin
                        ir      <= 32'(mem_rdata);
                        pc      <= pc + ADDR_W'(1);
                        mem_req <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    a       <= regs[rs];
                    b       <= regs[rt];
                    alu_out <= DATA_W'(pc) + imm_ext;
                    if (op == OP_HALT || (!op_ok && ALLOW_ILLEGAL_HALT != 0)) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        illegal <= !op_ok;
                    end else if (!op_ok) begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else begin
                        case (op)
                            OP_R:         state <= EXEC_R;
                            OP_LW, OP_SW: state <= MEM_ADDR;
                            OP_ADDI:      state <= EXEC_I;
                            OP_BEQ:       state <= BRANCH;
                            OP_J:         state <= JUMP;
                            default:      state <= FETCH;
                        endcase
                    end
                end
                EXEC_R: begin
                    alu_out <= alu_r;
                    state   <= WB_R;
                end
                WB_R: begin
                    if (rd != 5'd0) regs[rd] <= alu_out;
                    state    <= FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                end
                EXEC_I: begin
                    alu_out <= eff_addr;
                    state   <= WB_I;
                end
                WB_I: begin
                    if (rt != 5'd0) regs[rt] <= alu_out;
                    state    <= FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                end
                MEM_ADDR: begin
                    alu_out  <= eff_addr;
                    mem_req  <= 1'b1;
                    mem_addr <= eff_addr[ADDR_W-1:0];
                    if (op == OP_SW) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= b;
                        state     <= MEM_WR;
                    end else begin
                        mem_we <= 1'b0;
                        state  <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_ready) begin
                        mdr     <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= MEM_WB;
                    end
                end
                MEM_WB: begin
                    if (rt != 5'd0) regs[rt] <= mdr;
                    state    <= FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                end
                MEM_WR: begin
                    if (mem_ready) begin
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_addr  <= pc;
                        state     <= FETCH;
                    end
                end
                BRANCH: begin
                    if (a == b) begin
                        pc       <= alu_out[ADDR_W-1:0];
                        mem_addr <= alu_out[ADDR_W-1:0];
                    end else begin
                        mem_addr <= pc;
                    end
                    mem_req <= 1'b1;
                    mem_we  <= 1'b0;
                    state   <= FETCH;
                end
                JUMP: begin
                    pc       <= ir[ADDR_W-1:0];
                    mem_addr <= ir[ADDR_W-1:0];
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    state    <= FETCH;
                end
                HALT: begin
                    mem_req <= 1'b0;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready;
    logic [7:0]  mem_addr, pc_out;
    logic [31:0] mem_wdata, mem_rdata;
    logic        halted, illegal;

    logic        m2_req, m2_we;
    logic [7:0]  m2_addr, m2_pc;
    logic [31:0] m2_wdata, m2_rdata;
    logic        m2_halted, m2_illegal;

    logic [31:0] mem [256];
    int          fetch_edge [256];
    int          cyc = 0;
    int          wcnt = 0;
    int          wait_n = 0;
    logic        stall_hold = 1'b0;
    int          stall_err = 0;
    int          req_after_halt = 0;
    logic        pend = 1'b0;
    logic        p_we;
    logic [7:0]  p_addr;
    logic [31:0] p_wdata;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mips_multicycle_core #(.DATA_W(32), .ADDR_W(8), .ALLOW_ILLEGAL_HALT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .halted(halted), .illegal(illegal)
    );

    // Second core reads the same memory with zero wait and never writes it.
    mips_multicycle_core #(.DATA_W(32), .ADDR_W(8), .ALLOW_ILLEGAL_HALT(0)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .mem_req(m2_req), .mem_we(m2_we), .mem_addr(m2_addr),
        .mem_wdata(m2_wdata), .mem_rdata(m2_rdata), .mem_ready(1'b1),
        .pc_out(m2_pc), .halted(m2_halted), .illegal(m2_illegal)
    );

    assign mem_ready = mem_req && !stall_hold && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr];
    assign m2_rdata  = mem[m2_addr];

    always @(posedge clk) begin
        cyc <= rst_n ? cyc + 1 : 0;
        if (!rst_n || !mem_req || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (rst_n && mem_req && mem_ready) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else fetch_edge[mem_addr] <= cyc + 1;
        end
        if (rst_n && pend &&
            (!mem_req || mem_addr !== p_addr || mem_we !== p_we ||
             (mem_we && mem_wdata !== p_wdata)))
            stall_err <= stall_err + 1;
        pend    <= rst_n && mem_req && !mem_ready;
        p_addr  <= mem_addr;
        p_we    <= mem_we;
        p_wdata <= mem_wdata;
        if (rst_n && halted && mem_req) req_after_halt <= req_after_halt + 1;
    end

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    // Enter reset and blank memory; program words are written by the caller.
    task automatic start_load();
        rst_n = 1'b0;
        stall_hold = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            mem[i] <= 32'h0;
            fetch_edge[i] <= -1;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input int budget, output int cycles);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        cycles = cyc;
        if (!halted) begin
            tests_run++; tests_failed++;
            $display("FAIL halt_timeout: halted=%0b after %0d cycles, required 1", halted, n);
        end
    endtask

    task automatic test_reset();
        start_load();
        @(negedge clk);
        tests_run++;
        if ({mem_req, mem_we, halted, illegal} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: req/we/halted/illegal=%b, required 0000",
                     {mem_req, mem_we, halted, illegal});
        end
        tests_run++;
        if (pc_out !== 8'd0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_values: pc=%0d addr=%0d wdata=%h, required 0/0/0",
                     pc_out, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_zero_wait_add();
        int c;
        wait_n = 0;
        start_load();
        mem[0] <= enc_i(6'h08, 0, 1, 16'd5);
        mem[1] <= enc_i(6'h08, 0, 2, 16'hFFFD);
        mem[2] <= enc_r(1, 2, 3, 6'h20);
        mem[3] <= HALT_W;
        release_reset();
        run_until_halt(100, c);
        tests_run++;
        if (c !== 15) begin
            tests_failed++;
            $display("FAIL add_halt_cycle: got %0d, required 15", c);
        end
        tests_run++;
        if (dut.regs[3] !== 32'd2 || dut.regs[2] !== 32'hFFFF_FFFD) begin
            tests_failed++;
            $display("FAIL add_result: r3=%h r2=%h, required 2/fffffffd", dut.regs[3], dut.regs[2]);
        end
        tests_run++;
        if (illegal !== 1'b0 || pc_out !== 8'd4) begin
            tests_failed++;
            $display("FAIL add_state: illegal=%b pc=%0d, required 0/4", illegal, pc_out);
        end
    endtask

    task automatic test_lw_sw_wait();
        int c;
        wait_n = 2;
        start_load();
        mem[0]  <= enc_i(6'h23, 0, 1, 16'd20);
        mem[1]  <= enc_i(6'h2B, 0, 1, 16'd4);
        mem[2]  <= enc_i(6'h23, 0, 4, 16'd4);
        mem[3]  <= HALT_W;
        mem[20] <= 32'hDEAD_BEEF;
        release_reset();
        run_until_halt(200, c);
        tests_run++;
        if (mem[4] !== 32'hDEAD_BEEF || dut.regs[4] !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL lwsw_data: mem4=%h r4=%h, required deadbeef", mem[4], dut.regs[4]);
        end
        tests_run++;
        if (fetch_edge[3] - fetch_edge[2] !== 9) begin
            tests_failed++;
            $display("FAIL lw_cycles: got %0d, required 9", fetch_edge[3] - fetch_edge[2]);
        end
        tests_run++;
        if (fetch_edge[2] - fetch_edge[1] !== 8) begin
            tests_failed++;
            $display("FAIL sw_cycles: got %0d, required 8", fetch_edge[2] - fetch_edge[1]);
        end
        tests_run++;
        if (c !== 31) begin
            tests_failed++;
            $display("FAIL lwsw_halt_cycle: got %0d, required 31", c);
        end
        tests_run++;
        if (stall_err !== 0) begin
            tests_failed++;
            $display("FAIL stall_stability: %0d changes during stalls, required 0", stall_err);
        end
        wait_n = 0;
    endtask

    task automatic test_beq(input logic taken);
        int c;
        wait_n = 0;
        start_load();
        mem[0] <= enc_i(6'h08, 0, 1, 16'd7);
        mem[1] <= enc_i(6'h08, 0, 2, taken ? 16'd7 : 16'd8);
        mem[2] <= enc_i(6'h08, 0, 3, 16'd0);
        mem[3] <= enc_i(6'h04, 1, 2, 16'd2);
        mem[4] <= HALT_W;
        mem[5] <= HALT_W;
        mem[6] <= HALT_W;
        release_reset();
        run_until_halt(100, c);
        tests_run++;
        if (taken) begin
            if (fetch_edge[6] - fetch_edge[3] !== 3 || fetch_edge[4] !== -1 || pc_out !== 8'd7) begin
                tests_failed++;
                $display("FAIL beq_taken: dt=%0d f4=%0d pc=%0d, required 3/-1/7",
                         fetch_edge[6] - fetch_edge[3], fetch_edge[4], pc_out);
            end
        end else begin
            if (fetch_edge[4] - fetch_edge[3] !== 3 || fetch_edge[6] !== -1 || pc_out !== 8'd5) begin
                tests_failed++;
                $display("FAIL beq_not_taken: dt=%0d f6=%0d pc=%0d, required 3/-1/5",
                         fetch_edge[4] - fetch_edge[3], fetch_edge[6], pc_out);
            end
        end
    endtask

    task automatic test_jump_wrap();
        int c;
        wait_n = 0;
        start_load();
        mem[0]   <= enc_i(6'h04, 1, 0, 16'd1);
        mem[1]   <= HALT_W;
        mem[2]   <= {6'h02, 26'd254};
        mem[254] <= enc_i(6'h08, 0, 1, 16'd3);
        mem[255] <= enc_i(6'h08, 0, 2, 16'd4);
        release_reset();
        run_until_halt(200, c);
        tests_run++;
        if (dut.regs[1] !== 32'd3 || dut.regs[2] !== 32'd4 || pc_out !== 8'd2) begin
            tests_failed++;
            $display("FAIL jump_wrap_state: r1=%0d r2=%0d pc=%0d, required 3/4/2",
                     dut.regs[1], dut.regs[2], pc_out);
        end
        tests_run++;
        if (fetch_edge[254] - fetch_edge[2] !== 3) begin
            tests_failed++;
            $display("FAIL jump_cycles: got %0d, required 3", fetch_edge[254] - fetch_edge[2]);
        end
        tests_run++;
        if (fetch_edge[0] - fetch_edge[255] !== 4) begin
            tests_failed++;
            $display("FAIL pc_wrap: got %0d, required 4", fetch_edge[0] - fetch_edge[255]);
        end
    endtask

    task automatic test_zero_slt();
        int c;
        wait_n = 0;
        start_load();
        mem[0] <= enc_i(6'h08, 0, 0, 16'd9);
        mem[1] <= enc_i(6'h08, 0, 6, 16'hFFFF);
        mem[2] <= enc_i(6'h08, 0, 7, 16'd1);
        mem[3] <= enc_r(6, 7, 5, 6'h2A);
        mem[4] <= enc_r(7, 6, 8, 6'h2A);
        mem[5] <= enc_r(7, 6, 9, 6'h22);
        mem[6] <= enc_r(6, 7, 10, 6'h24);
        mem[7] <= enc_r(7, 9, 11, 6'h25);
        mem[8] <= enc_r(6, 7, 12, 6'h20);
        mem[9] <= HALT_W;
        release_reset();
        run_until_halt(200, c);
        tests_run++;
        if (dut.regs[0] !== 32'd0) begin
            tests_failed++;
            $display("FAIL reg0_write: r0=%h, required 0", dut.regs[0]);
        end
        tests_run++;
        if (dut.regs[5] !== 32'd1 || dut.regs[8] !== 32'd0) begin
            tests_failed++;
            $display("FAIL slt_signed: r5=%0d r8=%0d, required 1/0", dut.regs[5], dut.regs[8]);
        end
        tests_run++;
        if (dut.regs[9] !== 32'd2 || dut.regs[10] !== 32'd1 || dut.regs[11] !== 32'd3 ||
            dut.regs[12] !== 32'd0) begin
            tests_failed++;
            $display("FAIL alu_ops: sub=%h and=%h or=%h add=%h, required 2/1/3/0",
                     dut.regs[9], dut.regs[10], dut.regs[11], dut.regs[12]);
        end
    endtask

    task automatic test_illegal();
        int c;
        wait_n = 0;
        start_load();
        req_after_halt <= 0;
        mem[0] <= enc_i(6'h08, 0, 1, 16'd1);
        mem[1] <= 32'hF800_0000;
        mem[2] <= enc_i(6'h08, 0, 2, 16'd2);
        mem[3] <= HALT_W;
        release_reset();
        run_until_halt(100, c);
        tests_run++;
        if (c !== 7 || illegal !== 1'b1 || pc_out !== 8'd2) begin
            tests_failed++;
            $display("FAIL illegal_halt: cycle=%0d illegal=%b pc=%0d, required 7/1/2",
                     c, illegal, pc_out);
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if (req_after_halt !== 0 || dut.regs[2] !== 32'd0) begin
            tests_failed++;
            $display("FAIL illegal_quiet: reqs=%0d r2=%0d, required 0/0", req_after_halt, dut.regs[2]);
        end
        tests_run++;
        if (m2_halted !== 1'b1 || m2_illegal !== 1'b0 || dut2.regs[2] !== 32'd2 || m2_pc !== 8'd4) begin
            tests_failed++;
            $display("FAIL illegal_as_nop: halted=%b illegal=%b r2=%0d pc=%0d, required 1/0/2/4",
                     m2_halted, m2_illegal, dut2.regs[2], m2_pc);
        end
    endtask

    task automatic test_reset_mid_stall();
        int n = 0;
        wait_n = 0;
        start_load();
        mem[0] <= enc_i(6'h23, 0, 1, 16'd8);
        release_reset();
        while (!(mem_req && !mem_we && mem_addr == 8'd8) && n < 50) begin
            @(negedge clk);
            n++;
        end
        stall_hold = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'd8) begin
            tests_failed++;
            $display("FAIL stall_hold: req=%b addr=%0d, required 1/8", mem_req, mem_addr);
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b0 || pc_out !== 8'd0 || mem_addr !== 8'd0 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_stall: req=%b pc=%0d addr=%0d we=%b, required 0/0/0/0",
                     mem_req, pc_out, mem_addr, mem_we);
        end
        stall_hold = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'd0 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_fetch: req=%b addr=%0d we=%b, required 1/0/0",
                     mem_req, mem_addr, mem_we);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_add();
        test_lw_sw_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jump_wrap();
        test_zero_slt();
        test_illegal();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
